// File: rtl/vga_pkg.sv
// Shared widths, image geometry defaults, sync polarity and pixel types
// for the display-side pixel pipeline.
package vga_pkg;
   localparam int POS_W         = 10;
   localparam int GRAY_W        = 8;
   localparam int IMG_W_DEF     = 256;
   localparam int IMG_H_DEF     = 256;
   localparam int IMG0_BASE_DEF = 0;
   localparam int IMG1_BASE_DEF = 65536;

   localparam logic SYNC_ACTIVE = 1'b0;
   localparam logic SYNC_IDLE   = 1'b1;

   typedef logic [3*GRAY_W-1:0] rgb_t;

   typedef struct packed {
      logic in_img;
      logic h_sync;
      logic v_sync;
      logic blank_n;
   } video_ctl_t;

   localparam video_ctl_t CTL_IDLE = '{in_img: 1'b0, h_sync: SYNC_IDLE,
                                       v_sync: SYNC_IDLE, blank_n: 1'b0};

   function automatic rgb_t gray_to_rgb(input logic [GRAY_W-1:0] g);
      return {g, g, g};
   endfunction
endpackage

// File: rtl/vga_pixel_pipe_if.sv
// Video timing inputs, memory read port and aligned video outputs of the pipe.
interface vga_pixel_pipe_if import vga_pkg::*; #(
   parameter int N = 32
);
   logic [POS_W-1:0]  posx;
   logic [POS_W-1:0]  posy;
   logic              h_sync_in;
   logic              v_sync_in;
   logic              blank_n_in;
   logic [GRAY_W-1:0] pixel;
   logic [N-1:0]      pixel_address;
   logic              h_sync;
   logic              v_sync;
   logic              blank_n;
   rgb_t              RGB;

   modport master (
      output posx, posy, h_sync_in, v_sync_in, blank_n_in, pixel,
      input  pixel_address, h_sync, v_sync, blank_n, RGB
   );

   modport slave (
      input  posx, posy, h_sync_in, v_sync_in, blank_n_in, pixel,
      output pixel_address, h_sync, v_sync, blank_n, RGB
   );
endinterface

// File: rtl/vga_pixel_pipe_delay_line.sv
// Generic D-stage shift register with synchronous active-low reset to RST_VAL.
module delay_line #(
   parameter int           W       = 1,
   parameter int           D       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);
   genvar gi;
   generate
      for (gi = 0; gi < D; gi++) begin : g_stage
         logic [W-1:0] stage_reg;
         logic [W-1:0] stage_next;
         if (gi == 0) begin : g_first
            assign stage_next = din;
         end else begin : g_rest
            assign stage_next = g_stage[gi-1].stage_reg;
         end
         always_ff @(posedge clk) begin
            if (!reset) stage_reg <= RST_VAL;
            else        stage_reg <= stage_next;
         end
      end
   endgenerate

   assign dout = g_stage[D-1].stage_reg;
endmodule

// File: rtl/vga_pixel_pipe.sv
// Screen position -> pixel address, memory-latency alignment of video controls,
// gray RGB output, and frame-synchronous image switching from a raw button.
module vga_pixel_pipe import vga_pkg::*; #(
   parameter int                N         = 32,
   parameter int                MEM_LAT   = 1,
   parameter int                IMG_W     = IMG_W_DEF,
   parameter int                IMG_H     = IMG_H_DEF,
   parameter logic [N-1:0]      IMG0_BASE = N'(IMG0_BASE_DEF),
   parameter logic [N-1:0]      IMG1_BASE = N'(IMG1_BASE_DEF),
   parameter logic [GRAY_W-1:0] BORDER    = 8'h00
) (
   input  logic                 clk,
   input  logic                 reset,
   vga_pixel_pipe_if.slave      vif,
   input  logic                 chg_img,
   output logic                 img_sel,
   output logic [15:0]          frame_cnt
);
   localparam int LAT = MEM_LAT + 2;

   logic         in_img;
   logic [N-1:0] addr_next;
   logic [N-1:0] pixel_address_reg;
   video_ctl_t   ctl_in;
   video_ctl_t   ctl_d;

   rgb_t rgb_reg;
   logic h_sync_reg, v_sync_reg, blank_n_reg;

   logic        chg_meta_reg, chg_sync_reg, chg_prev_reg;
   logic        pending_reg, img_sel_reg, vs_prev_reg, armed_reg;
   logic [15:0] frame_cnt_reg;
   logic        press, frame_start;

   always_comb begin
      in_img    = (int'(vif.posx) < IMG_W) && (int'(vif.posy) < IMG_H) && vif.blank_n_in;
      addr_next = (img_sel_reg ? IMG1_BASE : IMG0_BASE)
                + N'(vif.posy) * N'(IMG_W) + N'(vif.posx);
      ctl_in    = '{in_img: in_img, h_sync: vif.h_sync_in,
                    v_sync: vif.v_sync_in, blank_n: vif.blank_n_in};
   end

   always_ff @(posedge clk) begin
      if (!reset)      pixel_address_reg <= IMG0_BASE;
      else if (in_img) pixel_address_reg <= addr_next;
   end

   // One stage fewer than LAT here: the output register supplies the last one.
   delay_line #(
      .W       ($bits(video_ctl_t)),
      .D       (LAT - 1),
      .RST_VAL (CTL_IDLE)
   ) u_ctl_dly (
      .clk   (clk),
      .reset (reset),
      .din   (ctl_in),
      .dout  (ctl_d)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         rgb_reg     <= '0;
         h_sync_reg  <= SYNC_IDLE;
         v_sync_reg  <= SYNC_IDLE;
         blank_n_reg <= 1'b0;
      end else begin
         h_sync_reg  <= ctl_d.h_sync;
         v_sync_reg  <= ctl_d.v_sync;
         blank_n_reg <= ctl_d.blank_n;
         if (!ctl_d.blank_n)    rgb_reg <= '0;
         else if (ctl_d.in_img) rgb_reg <= gray_to_rgb(vif.pixel);
         else                   rgb_reg <= gray_to_rgb(BORDER);
      end
   end

   // armed_reg masks the first post-reset cycle so a low v_sync_in at release
   // is not mistaken for a frame start.
   assign press       = chg_sync_reg & ~chg_prev_reg;
   assign frame_start = armed_reg && (vs_prev_reg == SYNC_IDLE) && (vif.v_sync_in == SYNC_ACTIVE);

   always_ff @(posedge clk) begin
      if (!reset) begin
         chg_meta_reg  <= 1'b0;
         chg_sync_reg  <= 1'b0;
         chg_prev_reg  <= 1'b0;
         pending_reg   <= 1'b0;
         img_sel_reg   <= 1'b0;
         vs_prev_reg   <= SYNC_IDLE;
         armed_reg     <= 1'b0;
         frame_cnt_reg <= '0;
      end else begin
         chg_meta_reg <= chg_img;
         chg_sync_reg <= chg_meta_reg;
         chg_prev_reg <= chg_sync_reg;
         vs_prev_reg  <= vif.v_sync_in;
         armed_reg    <= 1'b1;
         if (frame_start) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
            if (pending_reg || press) img_sel_reg <= ~img_sel_reg;
            pending_reg <= 1'b0;
         end else if (press) begin
            pending_reg <= 1'b1;
         end
      end
   end

   assign vif.pixel_address = pixel_address_reg;
   assign vif.RGB           = rgb_reg;
   assign vif.h_sync        = h_sync_reg;
   assign vif.v_sync        = v_sync_reg;
   assign vif.blank_n       = blank_n_reg;
   assign img_sel           = img_sel_reg;
   assign frame_cnt         = frame_cnt_reg;
endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Directed bench for vga_pixel_pipe: address, latency, border/blank,
// deferred image switching, frame counter wrap and mid-frame reset.
module tb_vga_pixel_pipe;
   import vga_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        chg_img = 1'b0;
   logic        img_sel;
   logic [15:0] frame_cnt;
   int          n_cmp = 0;
   int          n_err = 0;

   vga_pixel_pipe_if #(.N(32)) vif ();

   vga_pixel_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .vif       (vif),
      .chg_img   (chg_img),
      .img_sel   (img_sel),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   // Memory with one cycle of read latency; data is a fixed function of address.
   always @(posedge clk) vif.pixel <= vif.pixel_address[7:0] ^ 8'hAF;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   initial begin
      vif.posx = '0; vif.posy = '0;
      vif.h_sync_in = 1'b1; vif.v_sync_in = 1'b1; vif.blank_n_in = 1'b0;

      // Reset with random inputs
      for (int i = 0; i < 5; i++) begin
         vif.posx = 10'($urandom); vif.posy = 10'($urandom);
         vif.h_sync_in = 1'($urandom); vif.v_sync_in = 1'($urandom);
         vif.blank_n_in = 1'($urandom); chg_img = 1'($urandom);
         tick(1);
      end
      chk("rst_rgb",   vif.RGB, 32'h0);
      chk("rst_hsync", vif.h_sync, 32'h1);
      chk("rst_vsync", vif.v_sync, 32'h1);
      chk("rst_blank", vif.blank_n, 32'h0);
      chk("rst_addr",  vif.pixel_address, 32'h0);
      chk("rst_imgsel", img_sel, 32'h0);
      chk("rst_fcnt",  frame_cnt, 32'h0);
      vif.posx = '0; vif.posy = '0; chg_img = 1'b0;
      vif.h_sync_in = 1'b1; vif.v_sync_in = 1'b1; vif.blank_n_in = 1'b0;
      tick(1);
      reset = 1'b1;
      tick(3);

      // Address and 3-cycle latency, image 0
      vif.posx = 10; vif.posy = 2; vif.blank_n_in = 1'b1;
      tick(1); chk("addr_img0", vif.pixel_address, 32'd522);
      tick(1); chk("lat_rgb_t2", vif.RGB, 32'h0);
               chk("lat_blank_t2", vif.blank_n, 32'h0);
      tick(1); chk("lat_rgb_t3", vif.RGB, 32'hA5A5A5);
               chk("lat_blank_t3", vif.blank_n, 32'h1);

      // Sync pulse alignment and frame counting
      vif.h_sync_in = 1'b0; vif.v_sync_in = 1'b0;
      tick(1); chk("fcnt_1", frame_cnt, 32'd1);
      vif.h_sync_in = 1'b1; vif.v_sync_in = 1'b1;
      tick(1); chk("hs_t2", vif.h_sync, 32'h1);
      tick(1); chk("hs_t3", vif.h_sync, 32'h0);
               chk("vs_t3", vif.v_sync, 32'h0);
      tick(1); chk("hs_t4", vif.h_sync, 32'h1);
               chk("vs_t4", vif.v_sync, 32'h1);

      // Two presses within one frame -> single deferred toggle
      vif.posx = '0; vif.posy = '0; vif.blank_n_in = 1'b0;
      chg_img = 1'b1; tick(50);
      chg_img = 1'b0; tick(20);
      chg_img = 1'b1; tick(50);
      chg_img = 1'b0; tick(10);
      chk("sel_held", img_sel, 32'h0);
      vif.v_sync_in = 1'b0;
      tick(1); chk("sel_toggle", img_sel, 32'h1);
               chk("fcnt_2", frame_cnt, 32'd2);
      vif.v_sync_in = 1'b1; tick(10);
      vif.v_sync_in = 1'b0; tick(1);
      vif.v_sync_in = 1'b1;
      chk("sel_once", img_sel, 32'h1);
      chk("fcnt_3", frame_cnt, 32'd3);
      tick(5);

      // Address with image 1
      vif.posx = 10; vif.posy = 2; vif.blank_n_in = 1'b1;
      tick(1); chk("addr_img1", vif.pixel_address, 32'd66058);
      tick(2); chk("rgb_img1", vif.RGB, 32'hA5A5A5);

      // Border and blank
      vif.posx = 300;
      tick(1); chk("addr_border", vif.pixel_address, 32'd66058);
      tick(2); chk("rgb_border", vif.RGB, 32'h0);
               chk("blank_border", vif.blank_n, 32'h1);
      vif.posx = 5; vif.blank_n_in = 1'b0;
      tick(1); chk("addr_blank", vif.pixel_address, 32'd66058);
      tick(2); chk("rgb_blank", vif.RGB, 32'h0);
               chk("blank_out", vif.blank_n, 32'h0);
      vif.posx = 255; vif.posy = 255; vif.blank_n_in = 1'b1;
      tick(1); chk("addr_corner", vif.pixel_address, 32'd131071);
      tick(2); chk("rgb_corner", vif.RGB, 32'h505050);
      vif.posx = 0; vif.posy = 256;
      tick(1); chk("addr_row256", vif.pixel_address, 32'd131071);
      tick(2); chk("rgb_row256", vif.RGB, 32'h0);

      // Frame counter wrap
      force dut.frame_cnt_reg = 16'hFFFF;
      #1 release dut.frame_cnt_reg;
      tick(2); chk("fcnt_ffff", frame_cnt, 32'hFFFF);
      vif.v_sync_in = 1'b0;
      tick(1); chk("fcnt_wrap", frame_cnt, 32'h0);
               chk("sel_nowrap", img_sel, 32'h1);
      vif.v_sync_in = 1'b1; tick(3);

      // Reset mid-frame drops a pending toggle
      chg_img = 1'b1; tick(10);
      chg_img = 1'b0; tick(5);
      reset = 1'b0; vif.v_sync_in = 1'b0;
      tick(2); chk("mrst_sel", img_sel, 32'h0);
               chk("mrst_fcnt", frame_cnt, 32'h0);
               chk("mrst_rgb", vif.RGB, 32'h0);
               chk("mrst_hsync", vif.h_sync, 32'h1);
      reset = 1'b1;
      tick(3); chk("rel_nospur", frame_cnt, 32'h0);
      vif.v_sync_in = 1'b1; tick(3);
      vif.v_sync_in = 1'b0;
      tick(1); chk("rel_fcnt", frame_cnt, 32'd1);
               chk("rel_sel", img_sel, 32'h0);
      vif.v_sync_in = 1'b1; tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/vga_pixel_pipe.md
# vga_pixel_pipe

Display-side pixel pipeline between the VGA timing generator and the data memory's pixel read port. It converts the current screen position into a data-memory pixel address for the selected image and waits out the memory read latency. It then returns grayscale RGB together with sync and blank signals delayed by the same latency. It also debounces the image-change button so that image switches only take effect at frame boundaries, which prevents tearing.

## Interface
Parameters:
- N, 32, address width.
- MEM_LAT, 1, cycles from `pixel_address` valid to `pixel` valid; legal range 1..4.
- IMG_W, 256, image width in pixels.
- IMG_H, 256, image height in pixels.
- IMG0_BASE, 0, pixel address of image 0, pixel (0,0).
- IMG1_BASE, 65536, pixel address of image 1, pixel (0,0).
- BORDER, 8'h00, gray level for pixels outside the image.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-low reset; sampled on rising clk.
- posx  in  10  current column from the timing generator.
- posy  in  10  current row from the timing generator.
- h_sync_in  in  1  horizontal sync, active low.
- v_sync_in  in  1  vertical sync, active low.
- blank_n_in  in  1  1 = visible area.
- chg_img  in  1  raw, asynchronous button level; 1 = pressed.
- pixel  in  8  memory read data.
- pixel_address  out  N  registered read address to memory.
- h_sync  out  1  aligned horizontal sync.
- v_sync  out  1  aligned vertical sync.
- blank_n  out  1  aligned blank.
- RGB  out  24  {g,g,g} gray output.
- img_sel  out  1  image currently displayed.
- frame_cnt  out  16  completed-frame counter.

## Operation
- Stage A (registered):
  - in_img = posx < IMG_W && posy < IMG_H && blank_n_in.
  - pixel_address = (img_sel ? IMG1_BASE : IMG0_BASE) + posy*IMG_W + posx, computed at N bits with no overflow checking.
  - When in_img = 0, pixel_address holds its previous value.
- Alignment: in_img, h_sync_in, v_sync_in and blank_n_in are delayed together through LAT = MEM_LAT + 2 register stages.
- Output stage (registered): RGB = in_img_d ? {pixel,pixel,pixel} : {3{BORDER}}; force RGB = 0 when blank_n_d = 0.
- Button path:
  - chg_img passes through a 2-flop synchronizer.
  - A rising edge of the synchronized level sets `pending`.
- Frame start is the falling edge of v_sync_in, detected against its one-cycle-registered copy.
- At frame start:
  - frame_cnt increments, wrapping 65535 -> 0.
  - If pending = 1, img_sel toggles and pending clears.
- A synchronized rising edge in the same cycle as frame start toggles img_sel immediately; pending stays 0.
- Multiple presses within one frame cause exactly one toggle.
- img_sel changes only at frame start, so every address in a frame uses the same base.

## Timing
- Reset values:
  - pixel_address = IMG0_BASE, RGB = 0, blank_n = 0.
  - h_sync = 1, v_sync = 1, img_sel = 0, frame_cnt = 0, pending = 0.
  - Synchronizer flops = 0; all delay-stage contents are at inactive values (syncs 1, blank 0, in_img 0).
- Position to pixel_address: 1 cycle.
- Position/sync inputs to h_sync, v_sync, blank_n, RGB: LAT = MEM_LAT + 2 cycles (3 at default).
- Button press to pending: 3 cycles (2 synchronizer + edge detect).
- Reset asserted mid-frame: all state returns to reset values on the next edge. An image toggle that was pending is lost.
- Reset deasserted mid-frame: outputs resume LAT cycles after the first valid input, with no spurious frame_cnt increment unless a true v_sync_in falling edge occurs.

## Structure
- Shared package vga_pkg holds:
  - Position width (10) and gray width (8).
  - IMG_W/IMG_H defaults and IMG0_BASE/IMG1_BASE.
  - Sync polarity constants and the `rgb_t` typedef.
- Sub-module `delay_line #(W, D)`: a generic D-stage shift register with a synchronous active-low reset to a parameterized reset value. It is instantiated once for the {in_img, h, v, blank} bundle.

## Test plan
- Reset: hold reset = 0 for 5 cycles with random inputs -> RGB = 0, h_sync = 1, v_sync = 1, blank_n = 0, pixel_address = 0, img_sel = 0, frame_cnt = 0.
- Address: posx = 10, posy = 2, blank_n_in = 1, img_sel = 0 -> pixel_address = 522 one cycle later. With img_sel = 1 -> 66058.
- Latency: drive pixel = 8'hA5 matching the address from MEM_LAT cycles earlier -> RGB = 24'hA5A5A5 exactly 3 cycles after the position. h_sync/v_sync pulses are shifted by exactly 3 cycles.
- Border and blank:
  - posx = 300, blank_n_in = 1 -> RGB = 0 (BORDER), pixel_address unchanged.
  - blank_n_in = 0 -> RGB = 0, blank_n = 0.
- Deferred switch: press chg_img mid-frame for 50 cycles, twice -> img_sel unchanged until the next v_sync_in falling edge, then toggles once. frame_cnt increments by 1 per edge; the 65535 -> 0 wrap is checked.
- Reset mid-frame with pending = 1 -> after release, img_sel = 0 and no toggle at the next frame start.
